// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU opcodes, controller states and latency table
package fpu_pkg;
    localparam int OP_W    = 4;
    localparam int COUNT_W = 5;

    localparam logic [OP_W-1:0] FADD   = 4'd0;
    localparam logic [OP_W-1:0] FSUB   = 4'd1;
    localparam logic [OP_W-1:0] FMUL   = 4'd2;
    localparam logic [OP_W-1:0] FMADD  = 4'd3;
    localparam logic [OP_W-1:0] FMOV   = 4'd4;
    localparam logic [OP_W-1:0] FSGNJ  = 4'd5;
    localparam logic [OP_W-1:0] FDIV   = 4'd6;
    localparam logic [OP_W-1:0] FCMP   = 4'd7;
    localparam logic [OP_W-1:0] FCVTFI = 4'd8;
    localparam logic [OP_W-1:0] FCVT   = 4'd9;
    localparam logic [OP_W-1:0] FIRST_UNDEF = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fpu_state_t;

    function automatic logic [COUNT_W-1:0] fpu_latency(input logic [OP_W-1:0] op);
        case (op)
            FADD, FSUB:     fpu_latency = 5'd7;
            FMUL:           fpu_latency = 5'd5;
            FMADD:          fpu_latency = 5'd6;
            FMOV:           fpu_latency = 5'd0;
            FSGNJ, FCMP:    fpu_latency = 5'd1;
            FDIV:           fpu_latency = 5'd16;
            FCVTFI, FCVT:   fpu_latency = 5'd6;
            default:        fpu_latency = 5'd0;
        endcase
    endfunction

    // Zero-latency and undefined ops still hold the FPU for one cycle.
    function automatic logic [COUNT_W-1:0] fpu_occupancy(input logic [OP_W-1:0] op);
        logic [COUNT_W-1:0] lat;
        lat = fpu_latency(op);
        fpu_occupancy = (lat == '0) ? 5'd1 : lat;
    endfunction
endpackage

// File: rtl/fpu_rr_arbiter.sv
// rtl/fpu_rr_arbiter.sv - two-way round-robin grant with last-grant pointer
module fpu_rr_arbiter (
    input  logic       clock,
    input  logic       clear,
    input  logic [1:0] eligible,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last_q;

    always_comb begin
        grant = eligible;
        if (eligible == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant[1];
        end
    end
endmodule

// File: rtl/fpu_issue_arbiter.sv
// rtl/fpu_issue_arbiter.sv - shares one multi-cycle FPU between two requesters
module fpu_issue_arbiter
    import fpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [1:0]        req_valid,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [OP_W-1:0]   req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [TAG_W-1:0]  req_tag0,
    input  logic [TAG_W-1:0]  req_tag1,
    input  logic [1:0]        flush,
    output logic [1:0]        req_ready,
    output logic              fpu_sel,
    output logic [OP_W-1:0]   fpu_op,
    output logic [DATA_W-1:0] fpu_a,
    output logic [DATA_W-1:0] fpu_b,
    input  logic [DATA_W-1:0] fpu_result,
    output logic [1:0]        resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_illegal,
    output logic              busy
);
    fpu_state_t         state_q, state_d;
    logic [COUNT_W-1:0] count_q;
    logic [OP_W-1:0]    op_q;
    logic [DATA_W-1:0]  a_q, b_q;
    logic [TAG_W-1:0]   tag_q;
    logic               owner_q;
    logic [1:0]         eligible, grant;
    logic               can_accept, accept, flush_own, last_beat;

    // A requester flushing in the same cycle is never offered a grant.
    assign eligible = req_valid & ~flush;

    fpu_rr_arbiter u_arb (
        .clock    (clock),
        .clear    (clear),
        .eligible (eligible),
        .accept   (accept),
        .grant    (grant)
    );

    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign req_ready  = can_accept ? grant : 2'b00;
    assign accept     = |(req_valid & req_ready);
    assign flush_own  = flush[owner_q];
    assign last_beat  = (count_q == fpu_occupancy(op_q) - 5'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: begin
                if (flush_own) begin
                    state_d = ST_IDLE;
                end else if (last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = accept ? ST_BUSY : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count_q      <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            tag_q        <= '0;
            owner_q      <= 1'b0;
            resp_data    <= '0;
            resp_illegal <= 1'b0;
        end else if (accept) begin
            count_q <= '0;
            owner_q <= grant[1];
            op_q    <= grant[1] ? req_op1  : req_op0;
            a_q     <= grant[1] ? req_a1   : req_a0;
            b_q     <= grant[1] ? req_b1   : req_b0;
            tag_q   <= grant[1] ? req_tag1 : req_tag0;
        end else if (state_q == ST_BUSY) begin
            if (flush_own || last_beat) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + 5'd1;
            end
            if (!flush_own && last_beat) begin
                resp_data    <= fpu_result;
                resp_illegal <= (op_q >= FIRST_UNDEF);
            end
        end
    end

    assign fpu_sel    = (state_q == ST_BUSY);
    assign busy       = (state_q == ST_BUSY);
    assign fpu_op     = op_q;
    assign fpu_a      = a_q;
    assign fpu_b      = b_q;
    assign resp_tag   = tag_q;
    assign resp_valid = (state_q == ST_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
endmodule
